mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Controller and arbiter for a single-ported unified instruction/data memory in the pipelined RISC-V core. It shares the memory between the Fetch stage (instruction reads at PCF) and the Memory stage (loads/stores). It holds the core idle after reset until `trigger`, and drives the fetch stall and memory-stage stall. It also buffers one fetched instruction and discards in-flight fetches killed by a taken branch.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width. `DW/8` byte enables.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low. Low forces reset state immediately.
- `trigger`  in  1  start-of-execution pulse, sampled only in IDLE.
- `flush`  in  1  taken branch (PCSrcD). Kills the buffered or in-flight fetch.
- `if_req`  in  1  fetch wants the instruction at `if_addr`.
- `if_addr`  in  AW  PCF.
- `if_ready`  in  1  decode register can accept (not StallD, not `stall_mem`).
- `if_valid`  out  1  instruction buffer holds a valid word.
- `if_rdata`  out  DW  buffered instruction.
- `stall_f`  out  1  hold PC. Equals NOT(`if_valid` AND `if_ready`); 1 in IDLE.
- `dm_req`  in  1  load/store request, held until `dm_valid`.
- `dm_we`  in  1  1 = store.
- `dm_addr`  in  AW  data address.
- `dm_wdata`  in  DW  store data.
- `dm_be`  in  DW/8  store byte enables.
- `dm_valid`  out  1  data transaction completes this cycle.
- `dm_rdata`  out  DW  load data, valid with `dm_valid`.
- `stall_mem`  out  1  `dm_req` AND NOT `dm_valid`. Freezes M stage and everything older.
- `mem_req`  out  1  memory request, registered.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/AW/DW/DW/8  registered. Stable while `mem_req`=1.
- `mem_ack`  in  1  memory completes the current request; `mem_rdata` valid this cycle.
- `mem_rdata`  in  DW  read data.
- `running`  out  1  0 in IDLE, 1 otherwise.

## Operation
- States: IDLE, ARB, FETCH, DATA, DROP.
- Reset values: IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, buffer empty (`if_valid`=0, `if_rdata`=0), `dm_valid`=0, `running`=0, `stall_f`=1.
- IDLE: no requests issued. `trigger`=1 moves to ARB.
- Arbitration is evaluated in ARB, and in FETCH/DATA/DROP on the `mem_ack` cycle, so back-to-back transactions are possible. Fixed priority:
  - `dm_req` (not yet serviced) goes to DATA.
  - Otherwise `if_req`, AND buffer empty-or-consumed-this-cycle, AND NOT `flush`, goes to FETCH.
  - Otherwise ARB.
- On entering FETCH/DATA, register `mem_req`=1 with the winning address and controls. Fetch uses `mem_we`=0 and `mem_be`=all ones.
- FETCH + `mem_ack`: load `mem_rdata` into the buffer, unless `flush`=1 this cycle, in which case discard it.
- FETCH + `flush` without ack: go to DROP.
- DROP: wait for `mem_ack`, discard the data, then arbitrate.
- DATA + `mem_ack`: `dm_valid`=1 and `dm_rdata`=`mem_rdata` combinationally in that cycle. `flush` has no effect on DATA.
- Buffer:
  - Consumed when `if_valid` AND `if_ready`.
  - Cleared by `flush`, with priority over a simultaneous load.
  - Load and consume in the same cycle leaves the buffer full with the new word.
- `mem_req` drops to 0 in the cycle after the last ack when nothing is granted.
- `trigger` is ignored outside IDLE.
- Reset mid-transaction abandons the request. Memory must accept a request withdrawn by reset.

## Timing
- Fetch latency: `if_req` seen in ARB at cycle T gives `mem_req`=1 at T+1. `mem_ack` at T+1+L (L≥0) gives `if_valid`=1 at T+2+L.
- Peak fetch rate with `mem_ack` tied high and `if_ready`=1: one instruction per cycle.
- Data latency: `dm_valid` occurs in the same cycle as `mem_ack`. `stall_mem` is 1 from the first `dm_req` cycle through the cycle before `dm_valid`.
- A `dm_req` arriving while FETCH is in flight waits for that ack and is then granted next.
- `stall_f` and `stall_mem` are combinational from state and inputs. No other combinational input-to-output paths except `dm_rdata`/`dm_valid`.

## Test plan
- Reset, `trigger`=0 for 10 cycles → `mem_req`=0, `running`=0, `stall_f`=1. Pulse `trigger` with `if_addr`=0 → `running`=1 next cycle, `mem_req`=1 with `mem_addr`=0x0 one cycle later.
- Fetch with 3-cycle ack latency, `mem_rdata`=0x00500093, `if_ready`=1 → `if_valid`=1 with `if_rdata`=0x00500093 one cycle after the ack; `stall_f`=0 that cycle only.
- `dm_req` store (addr 0x100, wdata 0xDEADBEEF, be 0xF) and `if_req` in the same ARB cycle → DATA granted first with `mem_we`=1 and `mem_addr`=0x100. `stall_mem`=1 until `dm_valid`, then a fetch is issued.
- Fetch in flight to 0x8, `flush`=1 two cycles before the ack, `if_addr`→0x40 → that ack's data is never presented (`if_valid` stays 0), then `mem_addr`=0x40 is issued.
- Buffer full, `if_ready`=0 for 5 cycles with `mem_ack` high → no new fetch `mem_req`; `if_rdata` stable; `stall_f`=1.
- `reset` driven low mid-FETCH, off-edge → `mem_req`=0 and `if_valid`=0 immediately. After release, state is IDLE until `trigger`.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbiter and controller for the single-ported unified instruction/data
// memory of the pipelined RISC-V core. The Fetch stage (instruction reads
// at PCF) and the Memory stage (loads/stores) share the memory. The core
// stays idle after reset until 'trigger'. One fetched instruction is
// buffered, and fetches killed by a taken branch are discarded.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   trigger           start-of-execution pulse, sampled only in IDLE
//   flush             taken branch; kills the buffered or in-flight fetch
//   if_req/if_addr    fetch request at PCF
//   if_ready          decode register can accept the buffered word
//   if_valid/if_rdata instruction buffer contents
//   stall_f           hold PC
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be  load/store request, held until dm_valid
//   dm_valid/dm_rdata data transaction completes this cycle, load data
//   stall_mem         freezes the M stage and everything older
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  registered memory request
//   mem_ack/mem_rdata memory completion and read data
//   running           0 in IDLE, 1 otherwise
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trigger,
  input  logic          flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_ready,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          stall_f,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_mem,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          running
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    FETCH,
    DATA,
    DROP
  } state_t;

  state_t state, state_next;

  logic arb_active;
  logic dm_pending;
  logic buf_free;
  logic grant_dm;
  logic grant_if;
  logic load_buf;
  logic consume_buf;

  // Arbitration happens in ARB and on the ack cycle of any transaction so
  // that transactions can run back to back. A data request that is being
  // acknowledged right now has been serviced and must not win again.
  always_comb begin
    arb_active  = (state == ARB) ||
                  (((state == FETCH) || (state == DATA) || (state == DROP)) && mem_ack);
    dm_pending  = dm_req && !((state == DATA) && mem_ack);
    consume_buf = if_valid && if_ready;
    buf_free    = !if_valid || if_ready;
    grant_dm    = arb_active && dm_pending;
    grant_if    = arb_active && !dm_pending && if_req && buf_free && !flush;
    load_buf    = (state == FETCH) && mem_ack && !flush;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = ARB;
      FETCH:   if (!mem_ack && flush) state_next = DROP;
      default: state_next = state;
    endcase
    if (arb_active) begin
      if (grant_dm)      state_next = DATA;
      else if (grant_if) state_next = FETCH;
      else               state_next = ARB;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Request registers change only when arbitrating, which keeps them stable
  // for the whole life of a request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (arb_active) begin
      mem_req <= grant_dm || grant_if;
      if (grant_dm) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (grant_if) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end
    end
  end

  // Flush beats a simultaneous load; a load alongside a consume leaves the
  // new word in the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid <= 1'b0;
      if_rdata <= '0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (load_buf) begin
      if_valid <= 1'b1;
      if_rdata <= mem_rdata;
    end else if (consume_buf) begin
      if_valid <= 1'b0;
    end
  end

  assign running   = (state != IDLE);
  assign stall_f   = (state == IDLE) || !(if_valid && if_ready);
  assign dm_valid  = (state == DATA) && mem_ack;
  assign dm_rdata  = mem_rdata;
  assign stall_mem = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Directed sequences and randomized
// traffic are checked cycle by cycle against a transaction-level model:
// one optional outstanding memory transaction, a one-word instruction
// buffer and the last issued request fields.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        trigger;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        stall_f;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        running;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_rdata(if_rdata), .stall_f(stall_f),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .stall_mem(stall_mem), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        trigger;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } stim_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_running;
  bit          m_busy;
  bit          m_is_data;
  bit          m_dropped;
  logic [31:0] m_ibuf[$];
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  bit          m_last_dv;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.if_ready = 1'b1;
    return s;
  endfunction

  task automatic modelReset();
    m_running = 0;
    m_busy    = 0;
    m_is_data = 0;
    m_dropped = 0;
    m_ibuf.delete();
    m_last_dv = 0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_if_rdata", if_rdata, 32'd0);
    checkOutput("rst_dm_valid", 32'(dm_valid), 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_stall_f", 32'(stall_f), 32'd1);
  endtask

  // Drive one cycle of inputs at the falling edge, check all outputs
  // against the model, advance the model, and return at the next falling edge.
  task automatic applyStimulus(input stim_t s);
    bit ack_now;
    bit dv;
    bit had_word;
    bit can_issue;
    bit new_word;
    trigger   = s.trigger;
    flush     = s.flush;
    if_req    = s.if_req;
    if_addr   = s.if_addr;
    if_ready  = s.if_ready;
    dm_req    = s.dm_req;
    dm_we     = s.dm_we;
    dm_addr   = s.dm_addr;
    dm_wdata  = s.dm_wdata;
    dm_be     = s.dm_be;
    mem_ack   = s.mem_ack;
    mem_rdata = s.mem_rdata;
    #1;
    ack_now  = m_busy && s.mem_ack;
    dv       = ack_now && m_is_data;
    had_word = (m_ibuf.size() != 0);

    checkOutput("running", 32'(running), 32'(m_running));
    checkOutput("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) begin
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("mem_we", 32'(mem_we), 32'(m_we));
      checkOutput("mem_be", 32'(mem_be), 32'(m_be));
      if (m_is_data) checkOutput("mem_wdata", mem_wdata, m_wdata);
    end
    checkOutput("if_valid", 32'(if_valid), 32'(had_word));
    if (had_word) checkOutput("if_rdata", if_rdata, m_ibuf[0]);
    checkOutput("stall_f", 32'(stall_f), 32'(!m_running || !(had_word && s.if_ready)));
    checkOutput("dm_valid", 32'(dm_valid), 32'(dv));
    if (dv) checkOutput("dm_rdata", dm_rdata, s.mem_rdata);
    checkOutput("stall_mem", 32'(stall_mem), 32'(s.dm_req && !dv));
    m_last_dv = dv;

    if (!m_running) begin
      if (s.trigger) m_running = 1;
    end else begin
      can_issue = !m_busy || ack_now;
      new_word  = 0;
      if (ack_now) begin
        new_word = !m_is_data && !m_dropped && !s.flush;
        m_busy   = 0;
      end else if (m_busy && !m_is_data && s.flush) begin
        m_dropped = 1;
      end
      if (s.flush)                        m_ibuf.delete();
      else if (new_word)                  m_ibuf = '{s.mem_rdata};
      else if (had_word && s.if_ready)    m_ibuf.delete();
      if (can_issue) begin
        if (s.dm_req && !dv) begin
          m_busy = 1; m_is_data = 1; m_dropped = 0;
          m_addr = s.dm_addr; m_we = s.dm_we; m_wdata = s.dm_wdata; m_be = s.dm_be;
        end else if (s.if_req && (!had_word || s.if_ready) && !s.flush) begin
          m_busy = 1; m_is_data = 0; m_dropped = 0;
          m_addr = s.if_addr; m_we = 0; m_wdata = 32'd0; m_be = 4'hF;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    logic [31:0] held_word;
    bit          dm_hold;
    bit          tied;
    stim_t       dm_fields;

    clk = 0;
    reset = 0;
    s = idleStim();
    trigger = 0; flush = 0; if_req = 0; if_addr = 0; if_ready = 1;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    mem_ack = 0; mem_rdata = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkResetValues();
    reset = 1;

    $display("[TB] idle after reset, then trigger");
    repeat (10) applyStimulus(idleStim());
    checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
    checkOutput("idle_running", 32'(running), 32'd0);
    checkOutput("idle_stall_f", 32'(stall_f), 32'd1);
    s = idleStim(); s.trigger = 1; s.if_req = 1;
    applyStimulus(s);
    checkOutput("trig_running", 32'(running), 32'd1);
    s = idleStim(); s.if_req = 1;
    applyStimulus(s);
    checkOutput("first_mem_req", 32'(mem_req), 32'd1);
    checkOutput("first_mem_addr", mem_addr, 32'd0);

    $display("[TB] fetch with three cycles of ack latency");
    s = idleStim(); s.if_req = 1;
    repeat (3) applyStimulus(s);
    s = idleStim(); s.mem_ack = 1; s.mem_rdata = 32'h00500093;
    applyStimulus(s);
    checkOutput("lat_if_valid", 32'(if_valid), 32'd1);
    checkOutput("lat_if_rdata", if_rdata, 32'h00500093);

    $display("[TB] store and fetch requested together");
    s = idleStim(); s.if_req = 1; s.if_addr = 32'h4;
    s.dm_req = 1; s.dm_we = 1; s.dm_addr = 32'h100; s.dm_wdata = 32'hDEADBEEF; s.dm_be = 4'hF;
    applyStimulus(s);
    checkOutput("store_mem_we", 32'(mem_we), 32'd1);
    checkOutput("store_mem_addr", mem_addr, 32'h100);
    applyStimulus(s);
    s.mem_ack = 1;
    applyStimulus(s);
    checkOutput("after_store_we", 32'(mem_we), 32'd0);
    checkOutput("after_store_addr", mem_addr, 32'h4);
    s = idleStim(); s.mem_ack = 1; s.mem_rdata = 32'h00100113;
    applyStimulus(s);

    $display("[TB] flush while fetch in flight");
    s = idleStim(); s.if_req = 1; s.if_addr = 32'h8;
    applyStimulus(s);
    s.flush = 1; s.if_addr = 32'h40;
    applyStimulus(s);
    s.flush = 0;
    applyStimulus(s);
    s.mem_ack = 1; s.mem_rdata = 32'hBADBAD00;
    applyStimulus(s);
    checkOutput("flush_if_valid", 32'(if_valid), 32'd0);
    checkOutput("flush_new_addr", mem_addr, 32'h40);
    s = idleStim(); s.mem_ack = 1; s.mem_rdata = 32'h04000513;
    applyStimulus(s);
    applyStimulus(idleStim());

    $display("[TB] full buffer held by decode");
    s = idleStim(); s.if_req = 1; s.if_addr = 32'h44; s.mem_ack = 1;
    applyStimulus(s);
    held_word = 32'h12345678;
    s = idleStim(); s.mem_ack = 1; s.mem_rdata = held_word;
    applyStimulus(s);
    for (int i = 0; i < 5; i++) begin
      s = idleStim(); s.if_req = 1; s.if_addr = 32'h48; s.if_ready = 0;
      s.mem_ack = 1; s.mem_rdata = $urandom;
      applyStimulus(s);
      checkOutput("hold_mem_req", 32'(mem_req), 32'd0);
      checkOutput("hold_if_rdata", if_rdata, held_word);
    end

    $display("[TB] reset during a fetch");
    s = idleStim(); s.if_req = 1; s.if_addr = 32'h48;
    applyStimulus(s);
    checkOutput("pre_rst_mem_req", 32'(mem_req), 32'd1);
    mem_ack = 0;
    #3 reset = 0;
    #1;
    checkOutput("mid_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("mid_rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("mid_rst_running", 32'(running), 32'd0);
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1;
    s = idleStim(); s.if_req = 1;
    repeat (5) applyStimulus(s);
    checkOutput("post_rst_running", 32'(running), 32'd0);

    $display("[TB] randomized traffic");
    s = idleStim(); s.trigger = 1;
    applyStimulus(s);
    dm_hold = 0;
    tied = 0;
    dm_fields = '0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) tied = ~tied;
      if (!dm_hold && m_running && $urandom_range(0, 4) == 0) begin
        dm_hold            = 1;
        dm_fields.dm_we    = 1'($urandom_range(0, 1));
        dm_fields.dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_fields.dm_wdata = $urandom;
        dm_fields.dm_be    = 4'($urandom_range(0, 15));
      end
      s = idleStim();
      s.trigger   = ($urandom_range(0, 15) == 0);
      s.flush     = ($urandom_range(0, 9) == 0);
      s.if_req    = ($urandom_range(0, 3) != 0);
      s.if_addr   = $urandom & 32'hFFFF_FFFC;
      s.if_ready  = ($urandom_range(0, 3) != 0);
      s.dm_req    = dm_hold;
      s.dm_we     = dm_fields.dm_we;
      s.dm_addr   = dm_fields.dm_addr;
      s.dm_wdata  = dm_fields.dm_wdata;
      s.dm_be     = dm_fields.dm_be;
      s.mem_ack   = tied ? 1'b1 : ($urandom_range(0, 2) == 0);
      s.mem_rdata = $urandom;
      applyStimulus(s);
      if (m_last_dv) dm_hold = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
